// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display controller.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int unsigned N_DIGITS = 8;
  localparam int unsigned DD_STEPS = 32;

  localparam logic [7:0]  SEG_BLANK = 8'h00;
  localparam logic [7:0]  SEG_DASH  = 8'h40;
  localparam logic [31:0] DEC_MAX   = 32'd99_999_999;

  // Glyphs for nibble values 0..F (index 0 is the rightmost entry); dp is always 0.
  localparam logic [15:0][7:0] SEG_GLYPHS = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  // Add-3 correction on every BCD nibble >= 5, applied ahead of each shift.
  function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
    logic [31:0] r;
    r = bcd;
    for (int i = 0; i < 8; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Nibble to seven-segment glyph lookup.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_glyph_c
);

  assign o_glyph_c = SEG_GLYPHS[i_nibble];

endmodule

// File: rtl/seg_disp_ctrl.sv
// 8-digit multiplexed seven-segment controller with hex or decimal (double-dabble) loading.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        sys_clk_in,
  input  logic        sys_rst_n,
  input  logic [31:0] value_i,
  input  logic        value_valid_i,
  input  logic        mode_hex_i,
  output logic        busy_o,
  output logic [7:0]  seg_cs_pin,
  output logic [7:0]  seg_data_0_pin,
  output logic [7:0]  seg_data_1_pin
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_bin;
  logic [31:0]        r_bcd;
  logic               r_hex;
  logic               r_ovf;
  logic [4:0]         r_step;
  logic               r_busy;
  logic [7:0][7:0]    r_disp;
  logic [CNT_W-1:0]   r_scan_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_cs;
  logic [7:0]         r_data0;
  logic [7:0]         r_data1;

  logic               w_load;
  logic               w_ovf;
  logic [31:0]        w_nib_src;
  logic [7:0][7:0]    w_dec_glyph;
  logic [7:0][7:0]    w_glyph_sel;
  logic [7:0]         w_keep;

  assign w_load = (r_state == ST_IDLE) && value_valid_i;
  assign w_ovf  = !mode_hex_i && (value_i > DEC_MAX);

  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_nxt = (mode_hex_i || w_ovf) ? ST_COMMIT : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_step == 5'(DD_STEPS - 1)) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Conversion datapath; the display register only changes on the commit edge.
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_hex  <= 1'b0;
      r_ovf  <= 1'b0;
      r_step <= '0;
      r_busy <= 1'b0;
      r_disp <= '0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      unique case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_bin  <= value_i;
            r_bcd  <= '0;
            r_hex  <= mode_hex_i;
            r_ovf  <= w_ovf;
            r_step <= '0;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {bcd_adjust(r_bcd), r_bin} << 1;
          r_step         <= r_step + 5'd1;
        end
        ST_COMMIT: r_disp <= w_glyph_sel;
        default: ;
      endcase
    end
  end

  assign w_nib_src = r_hex ? r_bin : r_bcd;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg_hex_decoder u_dec (
      .i_nibble  (w_nib_src[4*g +: 4]),
      .o_glyph_c (w_dec_glyph[g])
    );
  end

  // A decimal digit is shown if it or any more significant digit is nonzero; digit 0 always shows.
  always_comb begin : p_blank
    logic v_any;
    v_any  = 1'b0;
    w_keep = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      v_any     = v_any | (|r_bcd[4*i +: 4]);
      w_keep[i] = v_any || (i == 0);
    end
  end

  always_comb begin
    w_glyph_sel = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_ovf)                   w_glyph_sel[i] = SEG_DASH;
      else if (r_hex || w_keep[i]) w_glyph_sel[i] = w_dec_glyph[i];
      else                         w_glyph_sel[i] = SEG_BLANK;
    end
  end

  // Free-running scan; outputs follow the registered digit index.
  always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_cs       <= 8'h01;
      r_data0    <= SEG_BLANK;
      r_data1    <= SEG_BLANK;
    end else begin
      if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
      r_cs    <= 8'b1 << r_idx;
      r_data0 <= r_idx[2] ? SEG_BLANK : r_disp[r_idx];
      r_data1 <= r_idx[2] ? r_disp[r_idx] : SEG_BLANK;
    end
  end

  assign busy_o         = r_busy;
  assign seg_cs_pin     = r_cs;
  assign seg_data_0_pin = r_data0;
  assign seg_data_1_pin = r_data1;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Scoreboard bench for seg_disp_ctrl: expected frames queued at load, compared after each scan.
`timescale 1ns/1ps
module tb_seg_disp_ctrl;

  localparam int unsigned SCAN_DIV_TB = 4;
  localparam logic [7:0] TB_GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic        clk;
  logic        rst_n;
  logic [31:0] value;
  logic        valid;
  logic        hex;
  logic        busy;
  logic [7:0]  cs;
  logic [7:0]  d0;
  logic [7:0]  d1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          busy_cycles;
  logic [63:0] cap_frame;
  bit          cap_ok;
  bit          cap_busy;
  logic [63:0] sb_q[$];

  seg_disp_ctrl #(.SCAN_DIV(SCAN_DIV_TB)) dut (
    .sys_clk_in     (clk),
    .sys_rst_n      (rst_n),
    .value_i        (value),
    .value_valid_i  (valid),
    .mode_hex_i     (hex),
    .busy_o         (busy),
    .seg_cs_pin     (cs),
    .seg_data_0_pin (d0),
    .seg_data_1_pin (d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Independent reference: division-based decimal digits, nibble slicing for hex.
  function automatic logic [63:0] model_frame(input logic [31:0] v, input bit is_hex);
    logic [63:0] f;
    logic [31:0] r;
    f = '0;
    if (is_hex) begin
      for (int i = 0; i < 8; i++) f[8*i +: 8] = TB_GLYPH[v[4*i +: 4]];
    end else if (v > 32'd99999999) begin
      for (int i = 0; i < 8; i++) f[8*i +: 8] = 8'h40;
    end else begin
      r = v;
      for (int i = 0; i < 8; i++) begin
        if (i == 0 || r != 0) f[8*i +: 8] = TB_GLYPH[r % 10];
        r = r / 10;
      end
    end
    return f;
  endfunction

  // Pulse a load and count cycles busy stays high (bounded).
  task automatic load_pulse(input logic [31:0] v, input bit is_hex);
    @(negedge clk);
    value = v; hex = is_hex; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  // Observe one full scan of the outputs into cap_frame.
  task automatic capture_frame();
    int w;
    int idx;
    cap_ok = 1'b1; cap_busy = 1'b0; cap_frame = '0;
    w = 0;
    while (cs !== 8'h01 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) cap_ok = 1'b0;
    for (int c = 0; c < 8 * SCAN_DIV_TB; c++) begin
      idx = -1;
      for (int k = 0; k < 8; k++) if (cs === 8'(1 << k)) idx = k;
      if (busy !== 1'b0) cap_busy = 1'b1;
      if (idx < 0) cap_ok = 1'b0;
      else if (idx < 4) begin
        cap_frame[8*idx +: 8] = d0;
        if (d1 !== 8'h00) cap_ok = 1'b0;
      end else begin
        cap_frame[8*idx +: 8] = d1;
        if (d0 !== 8'h00) cap_ok = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [63:0] exp;
    rst_n = 1'b0; valid = 1'b0; value = '0; hex = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, cs, d0, d1} !== {1'b0, 8'h01, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_hold: busy/cs/d0/d1=%b/%h/%h/%h required 0/01/00/00", busy, cs, d0, d1);
    end
    rst_n = 1'b1;
    sb_q.push_back(64'h0);
    capture_frame();
    exp = sb_q.pop_front();
    n_tests++;
    if (!cap_ok || cap_busy) begin
      n_fail++;
      $display("FAIL reset_scan: ok=%0b busy_seen=%0b required ok=1 busy_seen=0", cap_ok, cap_busy);
    end
    n_tests++;
    if (cap_frame !== exp) begin
      n_fail++;
      $display("FAIL reset_frame: got %h required %h", cap_frame, exp);
    end
  endtask

  task automatic test_load(input string name, input logic [31:0] v, input bit is_hex,
                           input int exp_busy);
    logic [63:0] exp;
    sb_q.push_back(model_frame(v, is_hex));
    load_pulse(v, is_hex);
    n_tests++;
    if (busy_cycles !== exp_busy) begin
      n_fail++;
      $display("FAIL %s_busy: %0d cycles required %0d", name, busy_cycles, exp_busy);
    end
    repeat (2) @(negedge clk);
    capture_frame();
    exp = sb_q.pop_front();
    n_tests++;
    if (!cap_ok) begin
      n_fail++;
      $display("FAIL %s_scan: scan protocol ok=%0b required 1", name, cap_ok);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (cap_frame[8*i +: 8] !== exp[8*i +: 8]) begin
        n_fail++;
        $display("FAIL %s_digit%0d: got %h required %h", name, i, cap_frame[8*i +: 8], exp[8*i +: 8]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int c;
    sb_q.push_back(model_frame(32'd13, 1'b0));
    @(negedge clk);
    value = 32'd13; hex = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    busy_cycles = 0;
    c = 0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      if (c == 1) begin value = 32'd21; valid = 1'b1; end
      if (c == 2) valid = 1'b0;
      c++;
      @(negedge clk);
    end
    valid = 1'b0;
    n_tests++;
    if (busy_cycles !== 33) begin
      n_fail++;
      $display("FAIL b2b_busy: %0d cycles required 33", busy_cycles);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_dropped: busy=%b required 0 (second request must not queue)", busy);
    end
    capture_frame();
    exp = sb_q.pop_front();
    n_tests++;
    if (!cap_ok || cap_frame !== exp) begin
      n_fail++;
      $display("FAIL b2b_frame: got %h ok=%0b required %h", cap_frame, cap_ok, exp);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] exp;
    @(negedge clk);
    value = 32'd4321; hex = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, cs, d0, d1} !== {1'b0, 8'h01, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL midrst_async: busy/cs/d0/d1=%b/%h/%h/%h required 0/01/00/00", busy, cs, d0, d1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (cs !== 8'h01) begin
      n_fail++;
      $display("FAIL midrst_cs_restart: cs=%h required 01", cs);
    end
    sb_q.push_back(64'h0);
    capture_frame();
    exp = sb_q.pop_front();
    n_tests++;
    if (!cap_ok || cap_busy || cap_frame !== exp) begin
      n_fail++;
      $display("FAIL midrst_blank: got %h ok=%0b busy_seen=%0b required %h ok=1 busy_seen=0",
               cap_frame, cap_ok, cap_busy, exp);
    end
    test_load("post_rst", 32'hDEADBEEF, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_load("hex", 32'h1234ABCD, 1'b1, 1);
    test_load("dec55", 32'd55, 1'b0, 33);
    test_load("dec0", 32'd0, 1'b0, 33);
    test_load("dec_ovf", 32'd100000000, 1'b0, 1);
    test_load("dec_max", 32'd99999999, 1'b0, 33);
    test_load("dec_mid", 32'd1020304, 1'b0, 33);
    test_load("hex_zero", 32'h00000000, 1'b1, 1);
    test_back_to_back();
    test_reset_mid_shift();
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
